crc32_stream_checker: RTL
=========================

Name: crc32_stream_checker

Overview:
- Byte-serial, receive-side CRC-32 checker for packet streams.
- Consumes one byte per cycle over a valid/ready interface. Each packet is payload bytes followed by a 4-byte CRC trailer.
- Computes CRC over the payload using the same algorithm as the team's combinational window hash:
  - poly 04C11DB7, init FFFFFFFF, bit order unreflected, no final XOR (CRC-32/MPEG-2).
- Compares the computed value with the trailer and reports a per-packet verdict through a held result handshake.

Parameters:
- LEN_W, 16, width of the payload byte counter; the counter saturates at 2**LEN_W-1.

Ports:
- clk_i  in  1  clock
- srst_i  in  1  synchronous reset, active-high
- data_i  in  8  stream byte
- valid_i  in  1  data_i valid
- last_i  in  1  marks the final byte of the packet (last trailer byte)
- ready_o  out  1  checker accepts a byte this cycle
- res_valid_o  out  1  verdict available; held until accepted
- res_ready_i  in  1  verdict consumer ready
- crc_ok_o  out  1  computed CRC equals received CRC and no length error
- len_err_o  out  1  packet shorter than 4 bytes
- crc_calc_o  out  32  CRC computed over the payload
- crc_recv_o  out  32  received trailer; first trailer byte = bits 31:24
- pay_len_o  out  LEN_W  payload byte count (total bytes - 4, saturating); 0 when len_err_o=1

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high on clk_i/srst_i.
  - Reset values: ready_o=1, res_valid_o=0, crc_ok_o=0, len_err_o=0, crc_calc_o=0, crc_recv_o=0, pay_len_o=0.
  - Internal state after reset: CRC register = FFFFFFFF, delay line cleared, fill count 0, state IDLE.
- A byte is accepted when valid_i && ready_o.
- 4-byte delay line:
  - Each accepted byte shifts into a 4-byte shift register.
  - Once 4 bytes are held, each newly accepted byte pushes the oldest byte out.
  - The pushed-out byte updates CRC = step(byte, CRC) and increments the payload counter.
  - When last_i is accepted, the CRC register covers exactly the payload and the delay line holds the trailer.
- States:
  - IDLE: no bytes of the current packet yet. An accept moves to FILL. An accept with last_i=1 moves to RESULT with len_err.
  - FILL: fewer than 4 bytes held; bytes shift in, no CRC update. When the 4th byte is accepted, go to RUN.
  - RUN: steady state; every accept updates the CRC with the outgoing byte.
  - last_i accepted in FILL or RUN goes to RESULT:
    - If total bytes < 4, set len_err_o=1 and crc_ok_o=0.
    - Otherwise crc_recv_o = delay line, crc_calc_o = CRC register, crc_ok_o = (crc_calc_o == crc_recv_o).
  - RESULT: res_valid_o=1 and ready_o=0; outputs stay stable. On res_ready_i, go to IDLE, reinitialise CRC/counter/fill, and set ready_o=1 in the next cycle.
- Latency: res_valid_o rises in the cycle after the accepted last byte. Minimum packet gap is 1 cycle when res_ready_i is tied high.
- Exactly 4 bytes with last_i on the 4th byte is legal: empty payload, crc_calc_o=FFFFFFFF, pay_len_o=0.
- valid_i low mid-packet: state holds, with no CRC or counter change.
- Payload counter saturates at 2**LEN_W-1; the CRC keeps updating.
- srst_i mid-packet or in RESULT: discard everything and return to reset state; no verdict is emitted.
- The datapath updates one byte per cycle. The combinational path is one byte step plus the 32-bit compare.

Decomposition:
- Shared package crc32_pkg, also used by the combinational hash:
  - CRC32_POLY = 32'h04C11DB7
  - CRC32_INIT = 32'hFFFFFFFF
  - function crc32_d8_step(byte, crc), the 8-bit parallel update.
  - enum crc_chk_state_t {IDLE, FILL, RUN, RESULT}
- No sub-module needed; the delay line and FSM stay in one module.

Test Plan:
- Payload ASCII "123456789" followed by 03 76 E6 E7, last on E7 -> crc_calc_o=0376E6E7, crc_recv_o=0376E6E7, crc_ok_o=1, pay_len_o=9.
- Same packet with trailer 03 76 E6 E6 -> crc_ok_o=0, crc_calc_o=0376E6E7, crc_recv_o=0376E6E6.
- Bytes FF FF FF FF, last on 4th -> crc_calc_o=FFFFFFFF, crc_ok_o=1, pay_len_o=0. Bytes AA BB, last on BB -> len_err_o=1, crc_ok_o=0.
- "123456789" packet with valid_i randomly deasserted and res_ready_i held low 5 cycles:
  - Verdict unchanged; res_valid_o held; ready_o=0 throughout.
  - Back-to-back second packet accepted one cycle after res_ready_i.
- srst_i asserted after 5 bytes of a packet, then a fresh "123456789"+trailer packet -> no stale verdict; crc_ok_o=1, pay_len_o=9.

Source files
------------

// File: rtl/crc32_pkg.sv
// Shared CRC-32/MPEG-2 definitions: polynomial, initial value, byte-wide
// update function and the stream checker state encoding.
package crc32_pkg;

    localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        RUN    = 2'd2,
        RESULT = 2'd3
    } crc_chk_state_t;

    // 8-bit parallel CRC update, MSB first (unreflected), no final XOR.
    function automatic logic [31:0] crc32_d8_step(input logic [7:0] data,
                                                  input logic [31:0] crc);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[31] ^ data[i];
            c  = {c[30:0], 1'b0} ^ (fb ? CRC32_POLY : 32'h0000_0000);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_stream_checker.sv
// Byte-serial receive-side CRC-32 checker. A 4-byte delay line keeps the
// trailer out of the CRC: only bytes pushed out of the delay line are hashed,
// so on the last byte the CRC covers the payload and the line holds the
// received CRC. The verdict is held until the consumer accepts it.
module crc32_stream_checker
    import crc32_pkg::*;
#(
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic [7:0]       data_i,
    input  logic             valid_i,
    input  logic             last_i,
    output logic             ready_o,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic             crc_ok_o,
    output logic             len_err_o,
    output logic [31:0]      crc_calc_o,
    output logic [31:0]      crc_recv_o,
    output logic [LEN_W-1:0] pay_len_o
);

    localparam logic [LEN_W-1:0] CNT_MAX  = {LEN_W{1'b1}};
    localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};

    crc_chk_state_t   state_r, state_s;
    logic [31:0]      crc_r, crc_s;
    logic [31:0]      dly_r, dly_s;
    logic [2:0]       fill_r, fill_s;
    logic [LEN_W-1:0] cnt_r, cnt_s;

    logic             ready_r, ready_s;
    logic             res_valid_r, res_valid_s;
    logic             crc_ok_r, crc_ok_s;
    logic             len_err_r, len_err_s;
    logic [31:0]      crc_calc_r, crc_calc_s;
    logic [31:0]      crc_recv_r, crc_recv_s;
    logic [LEN_W-1:0] pay_len_r, pay_len_s;

    logic             accept_s;
    logic [31:0]      dly_shift_s;
    logic [31:0]      crc_step_s;
    logic [LEN_W-1:0] cnt_inc_s;

    assign accept_s    = valid_i && ready_r;
    assign dly_shift_s = {dly_r[23:0], data_i};
    assign crc_step_s  = crc32_d8_step(dly_r[31:24], crc_r);
    assign cnt_inc_s   = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + LEN_W'(1));

    // Next-state, datapath and verdict computation.
    always_comb begin
        state_s     = state_r;
        crc_s       = crc_r;
        dly_s       = dly_r;
        fill_s      = fill_r;
        cnt_s       = cnt_r;
        ready_s     = ready_r;
        res_valid_s = res_valid_r;
        crc_ok_s    = crc_ok_r;
        len_err_s   = len_err_r;
        crc_calc_s  = crc_calc_r;
        crc_recv_s  = crc_recv_r;
        pay_len_s   = pay_len_r;

        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    dly_s  = {24'h00_0000, data_i};
                    fill_s = 3'd1;
                    if (last_i) begin
                        // Single-byte packet: too short to carry a trailer.
                        state_s     = RESULT;
                        ready_s     = 1'b0;
                        res_valid_s = 1'b1;
                        len_err_s   = 1'b1;
                        crc_ok_s    = 1'b0;
                        crc_calc_s  = crc_r;
                        crc_recv_s  = 32'h0000_0000;
                        pay_len_s   = CNT_ZERO;
                    end else begin
                        state_s = FILL;
                    end
                end else begin
                    state_s = IDLE;
                end
            end

            FILL: begin
                if (accept_s) begin
                    dly_s  = dly_shift_s;
                    fill_s = fill_r + 3'd1;
                    if (last_i) begin
                        state_s     = RESULT;
                        ready_s     = 1'b0;
                        res_valid_s = 1'b1;
                        if (fill_r == 3'd3) begin
                            // Exactly four bytes: empty payload, trailer only.
                            len_err_s  = 1'b0;
                            crc_calc_s = crc_r;
                            crc_recv_s = dly_shift_s;
                            crc_ok_s   = (crc_r == dly_shift_s);
                            pay_len_s  = cnt_r;
                        end else begin
                            len_err_s  = 1'b1;
                            crc_ok_s   = 1'b0;
                            crc_calc_s = crc_r;
                            crc_recv_s = 32'h0000_0000;
                            pay_len_s  = CNT_ZERO;
                        end
                    end else if (fill_r == 3'd3) begin
                        state_s = RUN;
                    end else begin
                        state_s = FILL;
                    end
                end else begin
                    state_s = FILL;
                end
            end

            RUN: begin
                if (accept_s) begin
                    // Oldest byte leaves the delay line and is hashed.
                    dly_s = dly_shift_s;
                    crc_s = crc_step_s;
                    cnt_s = cnt_inc_s;
                    if (last_i) begin
                        state_s     = RESULT;
                        ready_s     = 1'b0;
                        res_valid_s = 1'b1;
                        len_err_s   = 1'b0;
                        crc_calc_s  = crc_step_s;
                        crc_recv_s  = dly_shift_s;
                        crc_ok_s    = (crc_step_s == dly_shift_s);
                        pay_len_s   = cnt_inc_s;
                    end else begin
                        state_s = RUN;
                    end
                end else begin
                    state_s = RUN;
                end
            end

            RESULT: begin
                if (res_ready_i) begin
                    state_s     = IDLE;
                    crc_s       = CRC32_INIT;
                    dly_s       = 32'h0000_0000;
                    fill_s      = 3'd0;
                    cnt_s       = CNT_ZERO;
                    ready_s     = 1'b1;
                    res_valid_s = 1'b0;
                end else begin
                    state_s = RESULT;
                end
            end

            default: begin
                // Unreachable encoding: recover to a clean idle checker.
                state_s     = IDLE;
                crc_s       = CRC32_INIT;
                dly_s       = 32'h0000_0000;
                fill_s      = 3'd0;
                cnt_s       = CNT_ZERO;
                ready_s     = 1'b1;
                res_valid_s = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_r     <= IDLE;
            crc_r       <= CRC32_INIT;
            dly_r       <= 32'h0000_0000;
            fill_r      <= 3'd0;
            cnt_r       <= CNT_ZERO;
            ready_r     <= 1'b1;
            res_valid_r <= 1'b0;
            crc_ok_r    <= 1'b0;
            len_err_r   <= 1'b0;
            crc_calc_r  <= 32'h0000_0000;
            crc_recv_r  <= 32'h0000_0000;
            pay_len_r   <= CNT_ZERO;
        end else begin
            state_r     <= state_s;
            crc_r       <= crc_s;
            dly_r       <= dly_s;
            fill_r      <= fill_s;
            cnt_r       <= cnt_s;
            ready_r     <= ready_s;
            res_valid_r <= res_valid_s;
            crc_ok_r    <= crc_ok_s;
            len_err_r   <= len_err_s;
            crc_calc_r  <= crc_calc_s;
            crc_recv_r  <= crc_recv_s;
            pay_len_r   <= pay_len_s;
        end
    end

    assign ready_o     = ready_r;
    assign res_valid_o = res_valid_r;
    assign crc_ok_o    = crc_ok_r;
    assign len_err_o   = len_err_r;
    assign crc_calc_o  = crc_calc_r;
    assign crc_recv_o  = crc_recv_r;
    assign pay_len_o   = pay_len_r;

endmodule
